// File: rtl/cu_mc_ctrl.sv
// cu_mc_ctrl: multi-cycle control unit with handshake RAM port, CALL/RET stack and halt/run control.
// Optional single-step input enabled by defining STEP_EN.
module cu_mc_ctrl #(
  parameter int DATAW     = 16,
  parameter int ADDRW     = 8,
  parameter int NREGS     = 16,
  parameter int OPW       = 5,
  parameter int NFLAGS    = 4,
  parameter int ALU_SUB   = 1,
  parameter int STK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDRW-1:0]  mem_addr,
  output logic [DATAW-1:0]  mem_wdata,
  input  logic [DATAW-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic [OPW-1:0]    alu_op,
  output logic [DATAW-1:0]  alu_a,
  output logic [DATAW-1:0]  alu_b,
  input  logic [DATAW-1:0]  alu_y,
  input  logic [NFLAGS-1:0] alu_flags,
  output logic              halted,
  output logic              stk_err
);
  localparam int RW   = $clog2(NREGS);
  localparam int SPW  = $clog2(STK_DEPTH);
  localparam int IMMW = DATAW - OPW - RW;
  localparam int IXW  = (DATAW > OPW + 3*RW) ? DATAW : OPW + 3*RW;
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'h10);
  localparam logic [OPW-1:0] OP_STI  = OPW'(5'h11);
  localparam logic [OPW-1:0] OP_LD   = OPW'(5'h12);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'h13);
  localparam logic [OPW-1:0] OP_MOV  = OPW'(5'h14);
  localparam logic [OPW-1:0] OP_CMP  = OPW'(5'h15);
  localparam logic [OPW-1:0] OP_BI   = OPW'(5'h16);
  localparam logic [OPW-1:0] OP_BCI  = OPW'(5'h17);
  localparam logic [OPW-1:0] OP_BNEI = OPW'(5'h18);
  localparam logic [OPW-1:0] OP_CALL = OPW'(5'h19);
  localparam logic [OPW-1:0] OP_RET  = OPW'(5'h1A);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'h1F);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALTED} state_t;

  state_t            state_q, state_d, done_st;
  logic [ADDRW-1:0]  pc_q, pc_d;
  logic [DATAW-1:0]  instr_q, instr_d;
  logic [DATAW-1:0]  regs_q [NREGS];
  logic [DATAW-1:0]  regs_d [NREGS];
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [SPW:0]      sp_q, sp_d, sp_m1;
  logic [ADDRW-1:0]  stk_q [STK_DEPTH];
  logic [ADDRW-1:0]  stk_d [STK_DEPTH];
  logic              stk_err_q, stk_err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDRW-1:0]  mem_addr_q, mem_addr_d;
  logic [DATAW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [OPW-1:0]    alu_op_q, alu_op_d;
  logic [DATAW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic              halted_q, halted_d;
  logic              wake;
  logic [IXW-1:0]    ix;
  logic [OPW-1:0]    op;
  logic [RW-1:0]     rx, ry, rz;
  logic [IMMW-1:0]   imm;
  logic [ADDRW-1:0]  tgt;

  // rz may extend past the word; missing upper bits read as zero
  assign ix    = IXW'(instr_q);
  assign op    = ix[OPW-1:0];
  assign rx    = ix[OPW +: RW];
  assign ry    = ix[OPW+RW +: RW];
  assign rz    = ix[OPW+2*RW +: RW];
  assign imm   = instr_q[DATAW-1:OPW+RW];
  assign tgt   = instr_q[OPW+ADDRW-1:OPW];
  assign sp_m1 = sp_q - (SPW+1)'(1);

`ifdef STEP_EN
  assign done_st = run ? S_FETCH : S_HALTED;
  assign wake    = run | step;
`else
  assign done_st = S_FETCH;
  assign wake    = run;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    sp_d        = sp_q;
    stk_d       = stk_q;
    stk_err_d   = stk_err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    case (state_q)
      S_FETCH: if (mem_req_q && mem_ready) begin
        instr_d = mem_rdata;
        pc_d    = pc_q + ADDRW'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = done_st;
        if (op < OPW'(16) || op == OP_CMP) begin
          alu_op_d = op == OP_CMP ? OPW'(ALU_SUB) : op;
          alu_a_d  = op == OP_CMP ? regs_q[rx] : regs_q[ry];
          alu_b_d  = op == OP_CMP ? regs_q[ry] : regs_q[rz];
          state_d  = S_EXEC;
        end else if (op == OP_LDI) regs_d[rx] = DATAW'(imm);
        else if (op == OP_MOV) regs_d[rx] = regs_q[ry];
        else if (op == OP_LD || op == OP_ST || op == OP_STI) begin
          mem_we_d    = op != OP_LD;
          mem_addr_d  = op == OP_STI ? regs_q[rx][ADDRW-1:0] : regs_q[ry][ADDRW-1:0];
          mem_wdata_d = op == OP_STI ? DATAW'(imm) : regs_q[rx];
          state_d     = S_MEM;
        end else if (op == OP_BI || (op == OP_BCI && flags_q[3]) || (op == OP_BNEI && !flags_q[1])) pc_d = tgt;
        else if (op == OP_CALL) begin
          if (sp_q == (SPW+1)'(STK_DEPTH)) begin
            stk_err_d = 1'b1;
            state_d   = S_HALTED;
          end else begin
            stk_d[sp_q[SPW-1:0]] = pc_q;
            sp_d = sp_q + (SPW+1)'(1);
            pc_d = tgt;
          end
        end else if (op == OP_RET) begin
          if (sp_q == '0) begin
            stk_err_d = 1'b1;
            state_d   = S_HALTED;
          end else begin
            pc_d = stk_q[sp_m1[SPW-1:0]];
            sp_d = sp_m1;
          end
        end else if (op == OP_HALT) state_d = S_HALTED;
      end
      S_MEM: if (mem_req_q && mem_ready) begin
        if (!mem_we_q) regs_d[rx] = mem_rdata;
        state_d = done_st;
      end
      S_EXEC: begin
        flags_d = alu_flags;
        if (op != OP_CMP) regs_d[rx] = alu_y;
        state_d = done_st;
      end
      S_HALTED: state_d = wake ? S_FETCH : S_HALTED;
      default: state_d = S_FETCH;
    endcase
    // outputs are registered, so they follow the state being entered
    mem_req_d = state_d == S_FETCH || state_d == S_MEM;
    halted_d  = state_d == S_HALTED;
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
      mem_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      regs_q      <= '{default: '0};
      flags_q     <= '0;
      sp_q        <= '0;
      stk_q       <= '{default: '0};
      stk_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      sp_q        <= sp_d;
      stk_q       <= stk_d;
      stk_err_q   <= stk_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      halted_q    <= halted_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign halted    = halted_q;
  assign stk_err   = stk_err_q;
endmodule

// File: doc/cu_mc_ctrl.md
Name: cu_mc_ctrl

Overview:
- Parametrised successor to the team's multi-cycle CPU control unit.
- Fetches, decodes and executes one instruction at a time against an external RAM and ALU.
- Adds:
  - a ready/request memory handshake with arbitrary wait states;
  - synchronous reset;
  - hardware CALL/RET return-address stack;
  - halt/run control with status outputs.
- Sits between the RAM model and the ALU in the processor top level.

Parameters:
- DATAW, 16, register/RAM word width
- ADDRW, 8, address width (ADDRW <= DATAW-OPW)
- NREGS, 16, general registers (power of 2); RW = clog2(NREGS)
- OPW, 5, opcode width
- NFLAGS, 4, ALU flag width; bit 3 = carry, bit 1 = zero
- ALU_SUB, 1, ALU opcode driven for CMP
- STK_DEPTH, 4, return-stack entries (power of 2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  start/resume from HALTED
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDRW  access address
- mem_wdata  out  DATAW  write data
- mem_rdata  in  DATAW  read data, valid when mem_ready=1
- mem_ready  in  1  access complete this cycle
- alu_op  out  OPW  ALU opcode
- alu_a  out  DATAW  ALU operand 1
- alu_b  out  DATAW  ALU operand 2
- alu_y  in  DATAW  ALU result
- alu_flags  in  NFLAGS  ALU flags
- halted  out  1  core is in HALTED
- stk_err  out  1  sticky stack overflow/underflow

Behaviour:
- Encoding: op = instr[OPW-1:0]; rx, ry, rz = the next three RW fields upward; imm = instr[DATAW-1:OPW+RW]; tgt = instr[OPW+ADDRW-1:OPW].
- Opcodes:
  - 0x00-0x0F ALU: rx = ALU(ry, rz)
  - 0x10 LDI: rx = imm, zero-extended
  - 0x11 STI: RAM[rx] = imm
  - 0x12 LD: rx = RAM[ry]
  - 0x13 ST: RAM[ry] = rx
  - 0x14 MOV: rx = ry
  - 0x15 CMP: flags from ry-rz equivalent (rx, ry via ALU_SUB)
  - 0x16 BI
  - 0x17 BCI: branch if carry
  - 0x18 BNEI: branch if zero flag clear
  - 0x19 CALL
  - 0x1A RET
  - 0x1F HALT
  - Any other opcode is a NOP.
- All outputs are registered.
- Reset (rst_n=0 at an edge) clears:
  - pc, flags, all registers, stack pointer, stk_err, mem_req, mem_we, mem_addr, mem_wdata, alu_*;
  - halted clears to 0; state goes to FETCH (execution starts from address 0).
- Reset overrides any in-flight access; mem_req drops in the cycle after the reset edge.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready=1: instr latched, pc=pc+1, then DECODE.
  - DECODE:
    - LDI/MOV/NOP: write register, then FETCH.
    - BI/BCI/BNEI: if taken, pc=tgt; then FETCH.
    - CALL: push pc (already incremented), pc=tgt.
    - RET: pop into pc.
    - LD/ST/STI: set address/data, then MEM.
    - ALU/CMP: drive alu_op/a/b, then EXEC.
    - HALT: go to HALTED.
  - MEM: mem_req held with stable addr/we/wdata until the edge where mem_ready=1. LD writes rx=mem_rdata on that edge. Then FETCH.
  - EXEC: ALU ops write rx=alu_y and flags=alu_flags; CMP updates flags only. Then FETCH.
  - HALTED: halted=1, mem_req=0. run=1 at an edge returns to FETCH at the current pc.
- Zero-wait latency: LDI, MOV, branch, CALL, RET, NOP take 2 cycles; LD, ST, STI, ALU, CMP take 3. Each wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- Stack boundaries:
  - CALL with a full stack, or RET with an empty stack: instruction becomes a NOP, stk_err=1 (sticky until reset), then HALTED.
  - Stack full = STK_DEPTH entries.
- Register writes use the destination field; a destination equal to a source uses the old source value.
- Branch target wraps modulo 2^ADDRW; pc+1 at the top address wraps to 0.

Optional Feature:
- STEP_EN: adds input step (1 bit).
- When defined:
  - After each completed instruction the core enters HALTED unless run=1 is held.
  - A step=1 pulse in HALTED executes exactly one instruction, then returns to HALTED.
  - step is ignored in other states.
- When undefined: no step port; the core free-runs until HALT or a stack error.

Test Plan:
- Reset, zero-wait RAM with [LDI r1,#5; LDI r2,#3; ADD(0x00) r3,r1,r2; HALT] -> r3=8, halted=1 at cycle 9, pc=4.
- LD with mem_ready delayed 3 cycles -> mem_req/mem_addr stable for 4 cycles; rx gets mem_rdata on the ready edge; instruction takes 6 cycles.
- CMP r1,r1 (zero flag set) then BNEI 0x20 -> not taken, pc continues; CMP 5,3 then BNEI 0x20 -> pc=0x20.
- CALL 0x40 at address 0x10; RET at 0x40 -> execution resumes at 0x11; after five nested CALLs with STK_DEPTH=4 -> stk_err=1, halted=1, pc unchanged.
- rst_n=0 during a MEM wait -> next cycle mem_req=0, registers zeroed, fetch from address 0 after release.
- With STEP_EN defined, three step pulses from HALTED -> exactly three instructions retire, halted=1 between them.
